// File: rtl/pic_sync_ctrl.sv
// pic_sync_ctrl: synchronous programmable interrupt controller.
// N request lines with mask, IRR/ISR, fully nested priority (fixed or rotating order),
// edge or level trigger, normal or automatic EOI and a two-pulse INTA vector handshake.
module pic_sync_ctrl #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned DW      = 32,
  parameter int unsigned VEC_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic               wr,
  input  logic               rd,
  input  logic [2:0]         a,
  input  logic [DW-1:0]      din,
  output logic [DW-1:0]      dout,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta,
  output logic               int_o,
  output logic [VEC_W-1:0]   vec_o,
  output logic               vec_v
);

  localparam int unsigned   PW      = $clog2(NUM_IRQ);
  localparam logic [PW-1:0] PtrInit = PW'(NUM_IRQ - 1);

  localparam logic [2:0] AddrCtrl = 3'd0;
  localparam logic [2:0] AddrMask = 3'd1;
  localparam logic [2:0] AddrEoi  = 3'd2;
  localparam logic [2:0] AddrIrr  = 3'd3;
  localparam logic [2:0] AddrIsr  = 3'd4;
  localparam logic [2:0] AddrPtr  = 3'd5;

  typedef enum logic [0:0] {StIdle, StAck2} state_e;

  // Highest-priority set bit of v when p is the lowest-priority index. Returns {found, index}.
  function automatic logic [PW:0] prio_scan(input logic [NUM_IRQ-1:0] v,
                                            input logic [PW-1:0]      p);
    logic [PW:0] res;
    int          idx;
    res = '0;
    // Walk from lowest to highest priority so the last hit is the winner.
    for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
      idx = (int'(p) + 1 + k) % int'(NUM_IRQ);
      if (v[idx]) res = {1'b1, PW'(idx)};
    end
    return res;
  endfunction

  // Highest-priority pending request that outranks every in-service level. Returns {found, index}.
  function automatic logic [PW:0] elig_scan(input logic [NUM_IRQ-1:0] req,
                                            input logic [NUM_IRQ-1:0] isr,
                                            input logic [PW-1:0]      p);
    logic [PW:0] res;
    logic        stop;
    int          idx;
    res  = '0;
    stop = 1'b0;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      idx = (int'(p) + 1 + k) % int'(NUM_IRQ);
      if (!stop) begin
        // An in-service bit at equal or higher priority blocks everything below it.
        if (isr[idx]) begin
          stop = 1'b1;
        end else if (req[idx]) begin
          res  = {1'b1, PW'(idx)};
          stop = 1'b1;
        end
      end
    end
    return res;
  endfunction

  // Registered state
  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] irr_q, irr_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic               ltim_q, ltim_d;
  logic               aeoi_q, aeoi_d;
  logic               rotate_q, rotate_d;
  logic [7:0]         vec_base_q, vec_base_d;
  logic [PW-1:0]      win_q, win_d;
  logic               spur_q, spur_d;
  logic               inta_q;
  logic               int_q, int_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               vec_v_q, vec_v_d;
  logic [DW-1:0]      dout_q, rd_data;

  // Combinational helpers
  logic          inta_edge;
  logic          ctrl_wr;
  logic [PW:0]   elig;
  logic          elig_found;
  logic [PW-1:0] elig_idx;
  logic          ack_take;
  logic          ack_done_clr;
  logic [PW:0]   eoi_scan;
  logic          unused_din;

  assign inta_edge  = inta & ~inta_q;
  assign ctrl_wr    = cs & wr & (a == AddrCtrl);
  assign unused_din = ^din;

  // Priority resolution always works from registered state, so a same-cycle MASK write
  // does not affect an acknowledge in progress.
  always_comb begin
    elig       = elig_scan(irr_q & ~mask_q, isr_q, ptr_q);
    elig_found = elig[PW];
    elig_idx   = elig[PW-1:0];
  end

  // INTA handshake: next state, latched winner, vector pulse and CPU interrupt line.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    spur_d       = spur_q;
    ack_take     = 1'b0;
    ack_done_clr = 1'b0;
    vec_d        = vec_q;
    vec_v_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (inta_edge) begin
          state_d = StAck2;
          // An acknowledge with int_o low, or with nothing eligible, takes the spurious path.
          if (int_q && elig_found) begin
            win_d    = elig_idx;
            spur_d   = 1'b0;
            ack_take = 1'b1;
          end else begin
            win_d  = PtrInit;
            spur_d = 1'b1;
          end
        end
      end
      StAck2: begin
        if (inta_edge) begin
          state_d      = StIdle;
          vec_d        = VEC_W'(vec_base_q) + VEC_W'(win_q);
          vec_v_d      = 1'b1;
          ack_done_clr = aeoi_q & ~spur_q;
        end
      end
      default: state_d = StIdle;
    endcase
    // Re-initialisation wins over any handshake activity.
    if (ctrl_wr) begin
      state_d      = StIdle;
      win_d        = PtrInit;
      spur_d       = 1'b0;
      vec_v_d      = 1'b0;
      ack_take     = 1'b0;
      ack_done_clr = 1'b0;
    end
    int_d = (state_d == StIdle) && elig_found && !ctrl_wr;
  end

  // Request/service/mask/pointer/control updates from triggers, handshake and bus writes.
  always_comb begin
    irr_d      = irr_q;
    isr_d      = isr_q;
    mask_d     = mask_q;
    ptr_d      = ptr_q;
    ltim_d     = ltim_q;
    aeoi_d     = aeoi_q;
    rotate_d   = rotate_q;
    vec_base_d = vec_base_q;
    eoi_scan   = '0;

    if (ack_take) isr_d[elig_idx] = 1'b1;
    if (ack_done_clr) begin
      isr_d[win_q] = 1'b0;
      if (rotate_q) ptr_d = win_q;
    end

    // Level mode tracks the line; edge mode latches rising edges, a new edge beating the ack clear.
    if (ltim_q) begin
      irr_d = irq;
    end else begin
      if (ack_take) irr_d[elig_idx] = 1'b0;
      irr_d = irr_d | (irq & ~irq_q);
    end

    if (cs && wr) begin
      case (a)
        AddrMask: mask_d = din[NUM_IRQ-1:0];
        AddrEoi: begin
          // EOI acts on the ISR left after any same-cycle automatic EOI.
          if (din[8]) begin
            for (int n = 0; n < int'(NUM_IRQ); n++) begin
              if (int'(din[4:0]) == n && isr_d[n]) begin
                isr_d[n] = 1'b0;
                if (rotate_q) ptr_d = PW'(n);
              end
            end
          end else begin
            eoi_scan = prio_scan(isr_d, ptr_d);
            if (eoi_scan[PW]) begin
              isr_d[eoi_scan[PW-1:0]] = 1'b0;
              if (rotate_q) ptr_d = eoi_scan[PW-1:0];
            end
          end
        end
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      ltim_d     = din[0];
      aeoi_d     = din[1];
      rotate_d   = din[2];
      vec_base_d = din[15:8];
      irr_d      = '0;
      isr_d      = '0;
      mask_d     = '1;
      ptr_d      = PtrInit;
    end
  end

  // Register read multiplexer; unmapped and write-only addresses read as zero.
  always_comb begin
    rd_data = '0;
    case (a)
      AddrCtrl: rd_data[15:0]        = {vec_base_q, 5'b0, rotate_q, aeoi_q, ltim_q};
      AddrMask: rd_data[NUM_IRQ-1:0] = mask_q;
      AddrIrr:  rd_data[NUM_IRQ-1:0] = irr_q;
      AddrIsr:  rd_data[NUM_IRQ-1:0] = isr_q;
      AddrPtr:  rd_data[PW-1:0]      = ptr_q;
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      irq_q      <= '0;
      irr_q      <= '0;
      isr_q      <= '0;
      mask_q     <= '1;
      ptr_q      <= PtrInit;
      ltim_q     <= 1'b0;
      aeoi_q     <= 1'b0;
      rotate_q   <= 1'b0;
      vec_base_q <= '0;
      win_q      <= PtrInit;
      spur_q     <= 1'b0;
      inta_q     <= 1'b0;
      int_q      <= 1'b0;
      vec_q      <= '0;
      vec_v_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      ltim_q     <= ltim_d;
      aeoi_q     <= aeoi_d;
      rotate_q   <= rotate_d;
      vec_base_q <= vec_base_d;
      win_q      <= win_d;
      spur_q     <= spur_d;
      inta_q     <= inta;
      int_q      <= int_d;
      vec_q      <= vec_d;
      vec_v_q    <= vec_v_d;
      if (cs && rd) dout_q <= rd_data;
    end
  end

  assign dout  = dout_q;
  assign int_o = int_q;
  assign vec_o = vec_q;
  assign vec_v = vec_v_q;

endmodule
